vc_input_buffer_credit: RTL

- Receive-side counterpart of the output-port VC selector, located at each router input port.
- Accepts flits tagged with a VC id and stores them in per-VC FIFOs.
- Presents the head flit of each VC to the local switch and returns one credit pulse upstream per flit drained.
- Upstream credit counters pair with this block, so that the "credit" inputs of the upstream selector track free slots here exactly.

---
 rtl/vc_input_buffer_credit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/vc_input_buffer_credit.sv
`default_nettype none
// ============================================================================
// Module   : vc_input_buffer_credit
// Purpose  : Router input-port buffer. Incoming flits are steered by VC id
//            into per-VC FIFOs. The head flit of every VC is presented to the
//            switch. One registered credit pulse goes upstream per flit popped.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            flit_in/_valid/_vc- incoming flit, valid strobe, target VC
//            deq               - per-VC pop request
//            flit_out          - head flits, VC i in [i*F+1 : (i+1)*F]
//            vc_valid/vc_isNew - VC non-empty / VC completely empty
//            credit_out        - one-cycle credit pulse per popped flit
//            count             - per-VC occupancy 0..DEPTH
//            err_overflow      - sticky, write to a full VC without a pop
//            err_badvc         - sticky, valid flit with out-of-range VC id
// Revision : 1.0 - initial release
// ============================================================================
module vc_input_buffer_credit #(
    parameter int FLIT_SIZE = 32,
    parameter int VC_NUM    = 4,
    parameter int VC_ID_W   = 3,
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:FLIT_SIZE]             flit_in,
    input  logic                           flit_valid,
    input  logic [VC_ID_W-1:0]             flit_vc,
    input  logic [0:VC_NUM-1]              deq,
    output logic [1:FLIT_SIZE*VC_NUM]      flit_out,
    output logic [0:VC_NUM-1]              vc_valid,
    output logic [0:VC_NUM-1]              vc_isNew,
    output logic [0:VC_NUM-1]              credit_out,
    output logic [(PTR_W+1)*VC_NUM-1:0]    count,
    output logic                           err_overflow,
    output logic                           err_badvc
);

    localparam int             c_CW   = PTR_W + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic              w_badvc;
    logic [VC_NUM-1:0] w_ovf;
    logic              r_err_overflow;
    logic              r_err_badvc;

    assign w_badvc = flit_valid && (32'(flit_vc) >= VC_NUM);

    generate
        for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
            logic [1:FLIT_SIZE] r_mem [DEPTH];
            logic [PTR_W-1:0]   r_wr_ptr;
            logic [PTR_W-1:0]   r_rd_ptr;
            logic [c_CW-1:0]    r_count;
            logic               r_credit;
            logic               w_sel;
            logic               w_pop;
            logic               w_wr;

            assign w_sel = flit_valid && (32'(flit_vc) == v);
            assign w_pop = deq[v] && (r_count != '0);
            // A same-cycle pop frees the slot, so a full VC still accepts.
            assign w_wr  = w_sel && ((r_count != c_FULL) || w_pop);
            // At full the VC is non-empty, so deq alone implies a pop.
            assign w_ovf[v] = w_sel && (r_count == c_FULL) && !deq[v];

            // Storage is intentionally left out of reset.
            always_ff @(posedge clk) begin
                if (w_wr) begin
                    r_mem[r_wr_ptr] <= flit_in;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                    r_credit <= 1'b0;
                end else begin
                    r_credit <= w_pop;
                    // DEPTH is a power of two, so pointers wrap naturally.
                    if (w_wr) begin
                        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    end
                    case ({w_wr, w_pop})
                        2'b10:   r_count <= r_count + c_CW'(1);
                        2'b01:   r_count <= r_count - c_CW'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end

            assign flit_out[v*FLIT_SIZE+1 +: FLIT_SIZE] = r_mem[r_rd_ptr];
            assign count[v*c_CW +: c_CW]                = r_count;
            assign vc_valid[v]                          = (r_count != '0);
            assign vc_isNew[v]                          = (r_count == '0);
            assign credit_out[v]                        = r_credit;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_overflow <= 1'b0;
            r_err_badvc    <= 1'b0;
        end else begin
            r_err_overflow <= r_err_overflow | (|w_ovf);
            r_err_badvc    <= r_err_badvc | w_badvc;
        end
    end

    assign err_overflow = r_err_overflow;
    assign err_badvc    = r_err_badvc;

endmodule
`default_nettype wire
